// File: rtl/fp_align_pkg.sv
// Shared width and lane-slicing helpers for the mantissa alignment and
// adder-tree blocks.
package fp_align_pkg;

   // Output lane width: sign/overflow headroom + hidden bit + mantissa + guard zeros.
   function automatic int ow_f(input int sig_w, input int low_exp);
      return sig_w + 4 + low_exp;
   endfunction

   // Magnitude width: output lane minus the sign bit.
   function automatic int mw_f(input int sig_w, input int low_exp);
      return ow_f(sig_w, low_exp) - 1;
   endfunction

   // LSB index of lane 'lane' in a flat bus of 'w'-bit lanes.
   function automatic int lane_lo(input int lane, input int w);
      return lane * w;
   endfunction

   // Smallest power of two >= n, used to size balanced reduction trees.
   function automatic int pow2_ceil(input int n);
      int p;
      p = 1;
      while (p < n) p = p * 2;
      return p;
   endfunction

endpackage

// File: rtl/man_lane_shift.sv
// One lane of the aligner: right-shift of the hidden-bit magnitude by the
// exponent offset, sticky collection, saturation and output formatting.
module man_lane_shift
   import fp_align_pkg::*;
#(
   parameter int EXP_W   = 3,
   parameter int SIG_W   = 3,
   parameter int LOW_EXP = 2,
   localparam int OW     = ow_f(SIG_W, LOW_EXP),
   localparam int MW     = mw_f(SIG_W, LOW_EXP)
) (
   input  logic [SIG_W-1:0] man_i,
   input  logic [EXP_W-1:0] off_i,
   input  logic             sign_i,
   input  logic             tc_i,
   output logic [OW-1:0]    lane_o,
   output logic             sticky_o
);

   logic [MW-1:0]   mag;
   logic [MW-1:0]   mag_sh;
   logic [2*MW-1:0] wide;
   logic [OW-1:0]   ext;
   logic            sat;

   // Shift with a zero-extended window so the discarded bits land in the low half.
   always_comb begin
      mag      = MW'({3'b001, man_i}) << LOW_EXP;
      sat      = 32'(off_i) >= MW;
      wide     = {mag, {MW{1'b0}}} >> off_i;
      mag_sh   = sat ? '0 : wide[2*MW-1:MW];
      sticky_o = sat ? 1'b1 : |wide[MW-1:0];
      ext      = {1'b0, mag_sh};
      if (tc_i) lane_o = sign_i ? (OW'(0) - ext) : ext;
      else      lane_o = {sign_i, mag_sh};
   end

endmodule

// File: rtl/man_align_pipe.sv
// Two-stage mantissa aligner: stage 1 finds the common (max) exponent and
// per-lane offsets, stage 2 registers the shifted/formatted lanes.
// Valid/ready handshake on both ends with full-throughput back-pressure.
module man_align_pipe
   import fp_align_pkg::*;
#(
   parameter int LANES   = 4,
   parameter int EXP_W   = 3,
   parameter int SIG_W   = 3,
   parameter int LOW_EXP = 2,
   localparam int OW     = ow_f(SIG_W, LOW_EXP)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*EXP_W-1:0] exp_in,
   input  logic [LANES*SIG_W-1:0] man_in,
   input  logic [LANES-1:0]       sign_in,
   input  logic                   tc_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OW-1:0]    man_out,
   output logic [LANES-1:0]       sticky_out,
   output logic [EXP_W-1:0]       exp_max
);

   localparam int P = pow2_ceil(LANES);

   // Balanced max tree; unused leaves hold 0, the identity for unsigned max.
   function automatic logic [EXP_W-1:0] max_tree(input logic [LANES*EXP_W-1:0] e);
      logic [EXP_W-1:0] t [2*P];
      for (int k = 0; k < 2*P; k++) t[k] = '0;
      for (int i = 0; i < LANES; i++) t[P+i] = e[lane_lo(i, EXP_W) +: EXP_W];
      for (int k = P-1; k >= 1; k--) t[k] = (t[2*k] > t[2*k+1]) ? t[2*k] : t[2*k+1];
      return t[1];
   endfunction

   logic                         s1_vld_q, s2_vld_q;
   logic                         s1_adv, s2_adv;
   logic [EXP_W-1:0]             exp_mx_d, exp1_q, exp2_q;
   logic [LANES-1:0][EXP_W-1:0]  off_d, off_q;
   logic [LANES-1:0][SIG_W-1:0]  man1_q;
   logic [LANES-1:0]             sign1_q;
   logic                         tc1_q;
   logic [LANES-1:0][OW-1:0]     lane_d, man2_q;
   logic [LANES-1:0]             sticky_d, sticky2_q;

   assign s2_adv   = !s2_vld_q | out_ready;
   assign s1_adv   = !s1_vld_q | s2_adv;
   assign in_ready = s1_adv;

   // Common exponent and per-lane distance from it.
   always_comb begin
      exp_mx_d = max_tree(exp_in);
      for (int i = 0; i < LANES; i++)
         off_d[i] = exp_mx_d - exp_in[lane_lo(i, EXP_W) +: EXP_W];
   end

   // Stage 1 register: loads whenever it is free or draining into stage 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         exp1_q   <= '0;
         off_q    <= '0;
         man1_q   <= '0;
         sign1_q  <= '0;
         tc1_q    <= 1'b0;
      end else if (s1_adv) begin
         s1_vld_q <= in_valid;
         if (in_valid) begin
            exp1_q  <= exp_mx_d;
            off_q   <= off_d;
            man1_q  <= man_in;
            sign1_q <= sign_in;
            tc1_q   <= tc_mode;
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      man_lane_shift #(
         .EXP_W   (EXP_W),
         .SIG_W   (SIG_W),
         .LOW_EXP (LOW_EXP)
      ) u_lane (
         .man_i    (man1_q[g]),
         .off_i    (off_q[g]),
         .sign_i   (sign1_q[g]),
         .tc_i     (tc1_q),
         .lane_o   (lane_d[g]),
         .sticky_o (sticky_d[g])
      );
   end

   // Stage 2 register: output data held stable until the consumer takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_vld_q  <= 1'b0;
         man2_q    <= '0;
         sticky2_q <= '0;
         exp2_q    <= '0;
      end else if (s2_adv) begin
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) begin
            man2_q    <= lane_d;
            sticky2_q <= sticky_d;
            exp2_q    <= exp1_q;
         end
      end
   end

   assign out_valid  = s2_vld_q;
   assign man_out    = man2_q;
   assign sticky_out = sticky2_q;
   assign exp_max    = exp2_q;

endmodule

// File: doc/man_align_pipe.md
MAN_ALIGN_PIPE -- requirements
Module: man_align_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4: number of operand lanes, at least 2.
REQ-002 SHALL have parameter EXP_W, default 3: exponent width per lane.
REQ-003 SHALL have parameter SIG_W, default 3: stored mantissa width per lane.
REQ-004 SHALL have parameter LOW_EXP, default 2: guard zeros appended below the mantissa.
REQ-005 SHALL derive OW = SIG_W+4+LOW_EXP as the output lane width and MW = OW-1 as the magnitude width.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1: input beat valid.
REQ-009 SHALL have port in_ready, output, 1: module accepts the beat.
REQ-010 SHALL have port exp_in, input, LANES*EXP_W: lane i exponent in bits [EXP_W*i +: EXP_W].
REQ-011 SHALL have port man_in, input, LANES*SIG_W: lane i stored mantissa.
REQ-012 SHALL have port sign_in, input, LANES: lane i sign, 1 = negative.
REQ-013 SHALL have port tc_mode, input, 1: per-beat output format, 0 = sign-magnitude, 1 = two's complement.
REQ-014 SHALL have port out_valid, output, 1: output beat valid.
REQ-015 SHALL have port out_ready, input, 1: downstream accepts the beat.
REQ-016 SHALL have port man_out, output, LANES*OW: aligned lanes.
REQ-017 SHALL have port sticky_out, output, LANES: per-lane OR of all bits shifted out.
REQ-018 SHALL have port exp_max, output, EXP_W: common exponent of the output beat.

Function
REQ-019 A beat SHALL transfer on any edge where valid and ready are both high; without a transfer, an output beat's data SHALL be held stable while out_valid is high.
REQ-020 Stage 1 SHALL register exp_max as the unsigned maximum of all lane exponents, per-lane offset_i = exp_max - exp_i, mantissa, sign and tc_mode.
REQ-021 Stage 2 SHALL form the MW-bit magnitude {3'b001, man_i, LOW_EXP zeros} shifted right logically by offset_i, and SHALL register the result.
REQ-022 sticky_i SHALL be the OR of the bits discarded by the shift; offset 0 SHALL give sticky 0.
REQ-023 If offset_i >= MW, the magnitude SHALL be 0 and sticky_i SHALL be 1.
REQ-024 With tc_mode=0, lane output SHALL be {sign_i, magnitude}.
REQ-025 With tc_mode=1, lane output SHALL be the OW-bit zero-extended magnitude, negated when sign_i=1; a zero magnitude SHALL give 0 regardless of sign.
REQ-026 Latency SHALL be 2 cycles from input transfer to out_valid when there is no stall; throughput SHALL be 1 beat per cycle.
REQ-027 Each stage SHALL advance when it is empty or its downstream stage is advancing.
REQ-028 in_ready SHALL equal !s1_valid | s2_advance, combinational from out_ready.
REQ-029 A stall SHALL neither lose nor duplicate any beat.
REQ-030 On equal exponents in all lanes, every offset SHALL be 0.
REQ-031 tc_mode SHALL travel with its beat; mode changes between consecutive beats SHALL take effect per beat.

Reset
REQ-032 While rst is high, out_valid, internal stage valids, man_out, sticky_out and exp_max SHALL be 0; in_ready SHALL be 1.
REQ-033 Assertion of rst mid-operation SHALL discard all in-flight beats asynchronously.
REQ-034 The first transfer after reset SHALL be possible on the first clk edge after rst deasserts.

Structure
REQ-035 Package fp_align_pkg SHALL hold the OW/MW width functions and the lane-slice index helpers, shared with the adder-tree blocks.
REQ-036 One sub-module, man_lane_shift, SHALL implement per-lane shift, sticky, saturation and two's-complement conversion, instantiated LANES times.
REQ-037 The max-exponent reduction SHALL be a balanced comparator tree.

Verification
(All scenarios use the default parameters unless stated: OW=9, MW=8.)
REQ-038 exp={5,3,5,0}, man=3'b101 all lanes, sign=0, tc=0 -> two cycles later man_out lanes = {9'h034, 9'h00D, 9'h034, 9'h001}, sticky = {0,0,0,1}, exp_max = 5.
REQ-039 Same beat with sign lane0 = 1, tc=1 -> lane0 = 9'h1CC; with tc=0 -> lane0 = 9'h134.
REQ-040 EXP_W=4, exp={12,3,12,12} -> lane1 offset 9 >= MW, so lane1 = 0, sticky1 = 1.
REQ-041 Back-to-back beats with out_ready low for 3 cycles -> in_ready drops after 2 beats are held; all beats emerge in order, uncorrupted and unduplicated.
REQ-042 rst pulse while both stages hold beats -> out_valid falls immediately; no stale beat appears after reset.
REQ-043 Random beats against a reference model with random out_ready at 50% -> all lanes, sticky and exp_max match.
